fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of decode/immediate generation. Keeps the PC and issues word requests to instruction memory over a ready/valid interface. Buffers in-order responses in a small queue and hands {inst, pc} to decode with valid/ready. On a branch/jump redirect it flushes buffered and in-flight instructions.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited memory requests, in-order
// response queue toward decode, and flush/restart on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   pc;
  logic [CW-1:0] inflight, inflight_nxt;
  logic [CW-1:0] drop;
  logic [CW-1:0] count, count_nxt;
  logic [PW-1:0] pwr, prd, qwr, qrd;
  logic [CW:0]   occ;

  logic [31:0] paddr [QDEPTH];
  logic [31:0] qinst [QDEPTH];
  logic [31:0] qpc   [QDEPTH];

  logic req_fire, rsp_take, rsp_keep, dec_fire;

  // Request side: issue only while a queue slot is reserved for the response
  assign occ            = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = !rst && !redirect_valid && (occ < (CW+1)'(QDEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Response side: stray responses with nothing outstanding are ignored
  assign rsp_take = imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_take && (drop == '0) && !redirect_valid;

  assign dec_valid = !rst && (count != '0);
  assign dec_inst  = dec_valid ? qinst[qrd] : 32'h0;
  assign dec_pc    = dec_valid ? qpc[qrd]   : 32'h0;
  assign dec_fire  = dec_valid && dec_ready;

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire && !rsp_take)
      inflight_nxt = inflight + CW'(1);
    else if (!req_fire && rsp_take)
      inflight_nxt = inflight - CW'(1);
  end

  always_comb begin
    count_nxt = count;
    if (rsp_keep && !dec_fire)
      count_nxt = count + CW'(1);
    else if (!rsp_keep && dec_fire)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      pwr      <= '0;
      prd      <= '0;
      qwr      <= '0;
      qrd      <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (req_fire) pwr <= pwr + PW'(1);
      if (rsp_take) prd <= prd + PW'(1);
      if (redirect_valid) begin
        // Everything still outstanding now belongs to the abandoned path
        pc    <= redirect_pc & 32'hFFFF_FFFC;
        drop  <= inflight - (rsp_take ? CW'(1) : CW'(0));
        count <= '0;
        qrd   <= qwr;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (rsp_take && (drop != '0)) drop <= drop - CW'(1);
        if (rsp_keep) qwr <= qwr + PW'(1);
        if (dec_fire) qrd <= qrd + PW'(1);
        count <= count_nxt;
      end
    end
  end

  // Data storage carries no reset; validity is tracked by the counters above
  always_ff @(posedge clk) begin
    if (req_fire) paddr[pwr] <= pc;
    if (rsp_keep) begin
      qinst[qwr] <= imem_rsp_data;
      qpc[qwr]   <= paddr[prd];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency memory model
// and a decode-side stream monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;

  int nchk  = 0;
  int nfail = 0;
  int ndec  = 0;
  int cyc   = 0;
  int lat   = 1;
  logic [31:0] exp_pc = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In-order memory: request accepted at an edge returns lat cycles later
  typedef struct {
    logic [31:0] a;
    int          due;
  } ent_t;
  ent_t mq[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat - 1});
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= memfn(mq[0].a);
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  // Decode stream monitor, credit invariant and request-stability checks
  logic        pv = 1'b0;
  logic [31:0] pa = 32'h0;
  always @(negedge clk) begin
    if (!rst) begin
      if (dec_valid && dec_ready && !redirect_valid) begin
        chk("dec_pc_stream", dec_pc, exp_pc);
        chk("dec_inst_stream", dec_inst, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ndec++;
      end
      chk("credit_bound", {31'b0, (32'(dut.inflight) + 32'(dut.count)) <= 32'd2}, 32'd1);
      if (imem_rsp_valid)
        chk("rsp_has_inflight", {31'b0, dut.inflight != '0}, 32'd1);
      if (pv && !redirect_valid) begin
        chk("req_valid_held", {31'b0, imem_req_valid}, 32'd1);
        chk("req_addr_held", imem_req_addr, pa);
      end
      pv = imem_req_valid && !imem_req_ready;
      pa = imem_req_addr;
    end else begin
      pv = 1'b0;
    end
  end

  logic [31:0] infl;
  logic [31:0] rv;
  logic [31:0] held;

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) tick();

    // Reset state
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_dec_inst", dec_inst, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_pc", dut.pc, 32'h0);

    // Release: first request at 0, first decode 2 cycles later
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("second_req_addr", imem_req_addr, 32'h4);
    chk("dec_empty_b", {31'b0, dec_valid}, 32'd0);
    tick();
    chk("first_dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("first_dec_pc", dec_pc, 32'h0);
    chk("first_dec_inst", dec_inst, memfn(32'h0));

    // Decode stall: queue fills, requests stop, address held
    dec_ready = 1'b0;
    repeat (6) tick();
    chk("stall_count", 32'(dut.count), 32'd2);
    chk("stall_inflight", 32'(dut.inflight), 32'd0);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_head_pc", dec_pc, exp_pc);
    chk("stall_req_addr", imem_req_addr, exp_pc + 32'd8);
    held = imem_req_addr;
    tick();
    chk("stall_addr_stable", imem_req_addr, held);
    dec_ready = 1'b1;
    repeat (10) tick();

    // Redirect with two requests in flight
    lat = 3;
    for (int i = 0; i < 30 && dut.inflight != 2; i++) tick();
    chk("two_inflight", 32'(dut.inflight), 32'd2);
    infl = 32'(dut.inflight);
    rv   = {31'b0, imem_rsp_valid};
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    exp_pc         = 32'h0000_0100;
    #1;
    chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_pc", dut.pc, 32'h0000_0100);
    chk("redir_addr", imem_req_addr, 32'h0000_0100);
    chk("redir_drop", 32'(dut.drop), infl - rv);
    chk("redir_dec_empty", {31'b0, dec_valid}, 32'd0);
    for (int i = 0; i < 30 && !dec_valid; i++) tick();
    chk("redir_drop_done", 32'(dut.drop), 32'd0);
    chk("redir_first_dec", dec_pc, 32'h0000_0100);
    repeat (10) tick();

    // Redirect coinciding with a response and a decode handshake
    lat = 1;
    for (int i = 0; i < 40 && !(imem_rsp_valid && dec_valid && dut.drop == 0); i++) tick();
    chk("coinc_setup", {31'b0, imem_rsp_valid && dec_valid}, 32'd1);
    infl = 32'(dut.inflight);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    exp_pc         = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("coinc_dec_empty", {31'b0, dec_valid}, 32'd0);
    chk("coinc_drop", 32'(dut.drop), infl - 32'd1);
    chk("coinc_pc", dut.pc, 32'h0000_0200);
    repeat (10) tick();

    // Back-to-back redirects: the last target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_pc    = 32'h0000_0407;
    exp_pc         = 32'h0000_0404;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("b2b_pc", dut.pc, 32'h0000_0404);
    repeat (15) tick();

    // Random memory and decode backpressure, latency 3
    lat = 3;
    for (int i = 0; i < 200; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      dec_ready      = 1'($urandom_range(0, 1));
      tick();
    end
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    lat = 1;
    repeat (15) tick();

    // Address wrap at the top of the space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    exp_pc         = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !(imem_req_valid && imem_req_addr == 32'hFFFF_FFFC); i++) tick();
    chk("wrap_req_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    for (int i = 0; i < 10 && !imem_req_valid; i++) tick();
    chk("wrap_req_zero", imem_req_addr, 32'h0000_0000);
    repeat (20) tick();

    chk("stream_progress", {31'b0, ndec >= 60}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
